seven_seg_scanner: RTL and testbench

Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits. It holds a snapshot of a packed hex value and scans it one digit per slot, driving shared segment lines and one anode enable per digit. Per-digit decimal points, per-digit enables and optional leading-zero blanking are supported. It sits between datapath or debug registers and the board display pins, and supersedes single-digit direct decoding.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seven_seg_scanner_if.sv | 13 +
 rtl/seg7_hex_lut.sv | 32 +++
 rtl/seven_seg_scanner.sv | 110 +++++++++++
 tb/tb_seven_seg_scanner.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Segment encodings shared by the seven-segment scanner and its hex decoder.
// Patterns are active-low and packed {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Host-side load bus of the seven-segment scanner: display data plus capture strobe.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic                    load;

  modport master (output value, dp_in, digit_en, lz_blank, load);
  modport slave  (input  value, dp_in, digit_en, lz_blank, load);
endinterface

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver scanning a shadowed hex value,
// one digit per SCAN_DIV-cycle slot, with per-digit dp/enable and leading-zero blanking.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_scanner_if.slave    host,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam bit POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = POL_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic                  DP_OFF  = POL_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL_LOW}};

  logic [PW-1:0]           cnt;
  logic                    tick;
  logic [IW-1:0]           idx, idx_next;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_en;

  logic [3:0]            nib;
  logic                  dp_sel, en_sel, upper_zero, blank, show;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            lut_seg, seg_al, seg_d;
  logic                  dp_al, dp_d;
  logic [NUM_DIGITS-1:0] an_al, an_d;

  assign tick     = (cnt == CNT_LAST);
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= IDX_LAST;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
    end else if (host.load) begin
      sh_value <= host.value;
      sh_dp    <= host.dp_in;
      sh_en    <= host.digit_en;
    end
  end

  // Select by compare rather than variable part-select so a 1-digit build stays width-clean.
  always_comb begin
    nib        = '0;
    dp_sel     = 1'b0;
    en_sel     = 1'b0;
    an_sel     = '0;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == IW'(k)) begin
        nib       = sh_value[4*k +: 4];
        dp_sel    = sh_dp[k];
        en_sel    = sh_en[k];
        an_sel[k] = 1'b1;
      end
      if ((IW'(k) >= idx_next) && (sh_value[4*k +: 4] != 4'h0)) upper_zero = 1'b0;
    end
  end

  seg7_hex_lut u_lut (
    .nibble (nib),
    .seg    (lut_seg)
  );

  assign blank  = host.lz_blank && (idx_next != '0) && upper_zero && !dp_sel;
  assign show   = en_sel && !blank;
  assign seg_al = show ? lut_seg : SEG_BLANK;
  assign dp_al  = show ? ~dp_sel : 1'b1;
  assign an_al  = show ? ~an_sel : '1;

  assign seg_d = POL_LOW ? seg_al : ~seg_al;
  assign dp_d  = POL_LOW ? dp_al  : ~dp_al;
  assign an_d  = POL_LOW ? an_al  : ~an_al;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else if (tick) begin
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4-digit scan/blanking/race, 1-digit decode sweep,
// and an inverted-polarity instance sharing the 4-digit load bus.
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seven_seg_scanner_if #(.NUM_DIGITS(4)) bus ();
  seven_seg_scanner_if #(.NUM_DIGITS(1)) bus1 ();

  logic [6:0] seg, seg1, seg2;
  logic       dp, dp1, dp2;
  logic [3:0] an, an2;
  logic [0:0] an1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .host(bus), .seg(seg), .dp(dp), .an(an)
  );

  seven_seg_scanner #(.NUM_DIGITS(1), .SCAN_DIV(2), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .host(bus1), .seg(seg1), .dp(dp1), .an(an1)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst(rst), .host(bus), .seg(seg2), .dp(dp2), .an(an2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic restart(input logic [15:0] v, input logic [3:0] dpv,
                         input logic [3:0] en, input logic lz);
    @(negedge clk);
    rst      = 1'b1;
    bus.load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst          = 1'b0;
    bus.value    = v;
    bus.dp_in    = dpv;
    bus.digit_en = en;
    bus.lz_blank = lz;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Slot s appears at the negedge after posedge 4*(s+1) counted from reset release.
  task automatic frame(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                       input logic [3:0] en, input logic lz, input logic [15:0] ean,
                       input logic [27:0] eseg, input logic [3:0] edp);
    logic [6:0] inv_seg;
    logic [3:0] inv_an;
    restart(v, dpv, en, lz);
    repeat (2) @(negedge clk);
    check({tag, ".pre_seg"}, 32'(seg), 32'h7F);
    check({tag, ".pre_an"},  32'(an),  32'hF);
    check({tag, ".pre_dp"},  32'(dp),  32'h1);
    check({tag, ".pre_seg_inv"}, 32'(seg2), 32'h0);
    for (int s = 0; s < 5; s++) begin
      int k;
      k = s % 4;
      repeat ((s == 0) ? 1 : 2) @(negedge clk);
      check($sformatf("%s.an%0d", tag, s),  32'(an),  32'(ean[4*k +: 4]));
      check($sformatf("%s.seg%0d", tag, s), 32'(seg), 32'(eseg[7*k +: 7]));
      check($sformatf("%s.dp%0d", tag, s),  32'(dp),  32'(edp[k]));
      if (s == 0) begin
        inv_seg = ~eseg[6:0];
        inv_an  = ~ean[3:0];
        check({tag, ".seg_inv"}, 32'(seg2), 32'(inv_seg));
        check({tag, ".an_inv"},  32'(an2),  32'(inv_an));
      end
      if (s < 4) begin
        repeat (2) @(negedge clk);
        check($sformatf("%s.hold_an%0d", tag, s),  32'(an),  32'(ean[4*k +: 4]));
        check($sformatf("%s.hold_seg%0d", tag, s), 32'(seg), 32'(eseg[7*k +: 7]));
      end
    end
  endtask

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.value     = '0;
    bus.dp_in     = '0;
    bus.digit_en  = '0;
    bus.lz_blank  = 1'b0;
    bus.load      = 1'b0;
    bus1.value    = '0;
    bus1.dp_in    = '0;
    bus1.digit_en = 1'b1;
    bus1.lz_blank = 1'b0;
    bus1.load     = 1'b0;

    // Single-digit decode sweep
    repeat (2) @(negedge clk);
    check("rst_seg1", 32'(seg1), 32'h7F);
    check("rst_an1",  32'(an1),  32'h1);
    rst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      bus1.value = 4'(n);
      bus1.load  = 1'b1;
      @(negedge clk);
      bus1.load = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("dec%0h", n), 32'(seg1), 32'(tbl[n]));
    end
    check("dec_an1", 32'(an1), 32'h0);
    check("dec_dp1", 32'(dp1), 32'h1);

    // Scan order with dp on digit 2
    frame("scan", 16'h1234, 4'b0100, 4'b1111, 1'b0,
          {4'b0111, 4'b1011, 4'b1101, 4'b1110},
          {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
          4'b1011);

    // load on the tick cycle: slot 1 still shows old '3', slot 2 shows F
    repeat (3) @(negedge clk);
    bus.value    = 16'hFFFF;
    bus.dp_in    = 4'b0000;
    bus.digit_en = 4'b1111;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("race.an_old",  32'(an),  32'hD);
    check("race.seg_old", 32'(seg), 32'(7'b0110000));
    repeat (4) @(negedge clk);
    check("race.an_new",  32'(an),  32'hB);
    check("race.seg_new", 32'(seg), 32'(7'b0001110));
    check("race.dp_new",  32'(dp),  32'h1);

    // Asynchronous reset mid-slot
    #1 rst = 1'b1;
    #1;
    check("arst.seg", 32'(seg),  32'h7F);
    check("arst.an",  32'(an),   32'hF);
    check("arst.dp",  32'(dp),   32'h1);
    check("arst.seg_inv", 32'(seg2), 32'h0);

    frame("lz0040", 16'h0040, 4'b0000, 4'b1111, 1'b1,
          {4'b1111, 4'b1111, 4'b1101, 4'b1110},
          {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000},
          4'b1111);

    frame("lz0000", 16'h0000, 4'b0000, 4'b1111, 1'b1,
          {4'b1111, 4'b1111, 4'b1111, 4'b1110},
          {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
          4'b1111);

    frame("lzdp", 16'h0000, 4'b0100, 4'b1111, 1'b1,
          {4'b1111, 4'b1011, 4'b1111, 4'b1110},
          {7'b1111111, 7'b1000000, 7'b1111111, 7'b1000000},
          4'b1011);

    frame("en1010", 16'h1234, 4'b0000, 4'b1010, 1'b0,
          {4'b0111, 4'b1111, 4'b1101, 4'b1111},
          {7'b1111001, 7'b1111111, 7'b0110000, 7'b1111111},
          4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
